rf_text_cell_fetch: RTL and testbench

//  Video-side cell fetcher for the 32-bit text screen RAM (port B, read latency 1).
//  - Per text row: issues COLS sequential reads from a base address, wrapping the address.
//  - Buffers the returned 32-bit cells in a FIFO.
//  - Presents cells to the character generator with a valid/ready handshake.

---
 rtl/rf_text_cell_fetch.sv | 180 ++++++++++++++++++
 tb/tb_rf_text_cell_fetch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_text_cell_fetch.sv
// rf_text_cell_fetch: per-row text cell fetcher from screen RAM port B into an output FIFO.
// Build option RF_TEXT_FETCH_CURSOR_EN adds cursor compare that inverts bit 31 of the cursor cell.
//
// state | meaning
// IDLE  | waiting for start_i with non-zero cols_i
// FETCH | issuing row reads whenever FIFO credit allows
module rf_text_cell_fetch #(
    parameter  int TEXT_CELL_COUNT = 16384,
    parameter  int MAX_COLS        = 128,
    parameter  int FIFO_DEPTH      = 16,
    localparam int AWID            = $clog2(TEXT_CELL_COUNT),
    localparam int CW              = $clog2(MAX_COLS + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [AWID-1:0] base_i,
    input  logic [CW-1:0]   cols_i,
`ifdef RF_TEXT_FETCH_CURSOR_EN
    input  logic [AWID-1:0] cursor_adr_i,
    input  logic            cursor_en_i,
`endif
    output logic            ram_cs_o,
    output logic [AWID-1:0] ram_adr_o,
    input  logic [31:0]     ram_dat_i,
    output logic [31:0]     cell_o,
    output logic            cell_valid_o,
    input  logic            cell_ready_i,
    output logic            busy_o,
    output logic            ovr_o
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int PNDW = CNTW + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AWID-1:0] adr_q, adr_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic            ram_cs_q, ram_cs_d;
    logic [AWID-1:0] ram_adr_q, ram_adr_d;
    logic            inflight_q, inflight_d;
    logic            ovr_q, ovr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [31:0]     mem_q [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            not_empty;
    logic [31:0]     push_dat;
    logic [PNDW-1:0] pending;
    logic            issue_ok;

`ifdef RF_TEXT_FETCH_CURSOR_EN
    logic            cs_hit_q, cs_hit_d;
    logic            inf_hit_q, inf_hit_d;
`endif

    // A read is outstanding both while the request sits on the port and while its data
    // returns, so both stages are charged against FIFO space before issuing.
    always_comb begin
        pending  = PNDW'(count_q) + PNDW'(ram_cs_q) + PNDW'(inflight_q);
        issue_ok = (pending < PNDW'(FIFO_DEPTH));
    end

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        rem_d      = rem_q;
        ram_cs_d   = 1'b0;
        ram_adr_d  = ram_adr_q;
        ovr_d      = ovr_q;
        inflight_d = ram_cs_q;
`ifdef RF_TEXT_FETCH_CURSOR_EN
        cs_hit_d   = 1'b0;
        inf_hit_d  = cs_hit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i && (cols_i != '0)) begin
                    adr_d   = base_i;
                    rem_d   = cols_i;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (start_i) begin
                    ovr_d = 1'b1;
                end
                if (issue_ok) begin
                    ram_cs_d  = 1'b1;
                    ram_adr_d = adr_q;
                    adr_d     = adr_q + AWID'(1);
                    rem_d     = rem_q - CW'(1);
`ifdef RF_TEXT_FETCH_CURSOR_EN
                    cs_hit_d  = cursor_en_i && (adr_q == cursor_adr_i);
`endif
                    if (rem_q == CW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        not_empty = (count_q != '0);
        push      = inflight_q;
        pop       = not_empty && cell_ready_i;
`ifdef RF_TEXT_FETCH_CURSOR_EN
        push_dat  = ram_dat_i ^ {inf_hit_q, 31'b0};
`else
        push_dat  = ram_dat_i;
`endif
        wr_ptr_d  = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d  = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            rem_q      <= '0;
            ram_cs_q   <= 1'b0;
            ram_adr_q  <= '0;
            inflight_q <= 1'b0;
            ovr_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef RF_TEXT_FETCH_CURSOR_EN
            cs_hit_q   <= 1'b0;
            inf_hit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            rem_q      <= rem_d;
            ram_cs_q   <= ram_cs_d;
            ram_adr_q  <= ram_adr_d;
            inflight_q <= inflight_d;
            ovr_q      <= ovr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef RF_TEXT_FETCH_CURSOR_EN
            cs_hit_q   <= cs_hit_d;
            inf_hit_q  <= inf_hit_d;
`endif
        end
    end

    // Storage needs no reset: the count gates everything read out of it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign ram_cs_o     = ram_cs_q;
    assign ram_adr_o    = ram_adr_q;
    assign cell_valid_o = not_empty;
    assign cell_o       = not_empty ? mem_q[rd_ptr_q] : 32'h0;
    assign busy_o       = (state_q == ST_FETCH) | ram_cs_q | inflight_q | not_empty;
    assign ovr_o        = ovr_q;

endmodule

// File: tb/tb_rf_text_cell_fetch.sv
// Directed bench for rf_text_cell_fetch; RAM model returns the cell address as data.
// Cursor vectors are included when RF_TEXT_FETCH_CURSOR_EN is defined.
module tb_rf_text_cell_fetch;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [13:0] base_i;
    logic [7:0]  cols_i;
    logic        ram_cs_o;
    logic [13:0] ram_adr_o;
    logic [31:0] ram_dat_i;
    logic [31:0] cell_o;
    logic        cell_valid_o;
    logic        cell_ready_i;
    logic        busy_o;
    logic        ovr_o;
`ifdef RF_TEXT_FETCH_CURSOR_EN
    logic [13:0] cursor_adr_i;
    logic        cursor_en_i;
`endif

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [13:0] iss_q[$];
    int          iss_t[$];
    logic [31:0] cel_q[$];
    int          cel_t[$];

    always #5 clk_i = ~clk_i;

    rf_text_cell_fetch dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .base_i       (base_i),
        .cols_i       (cols_i),
`ifdef RF_TEXT_FETCH_CURSOR_EN
        .cursor_adr_i (cursor_adr_i),
        .cursor_en_i  (cursor_en_i),
`endif
        .ram_cs_o     (ram_cs_o),
        .ram_adr_o    (ram_adr_o),
        .ram_dat_i    (ram_dat_i),
        .cell_o       (cell_o),
        .cell_valid_o (cell_valid_o),
        .cell_ready_i (cell_ready_i),
        .busy_o       (busy_o),
        .ovr_o        (ovr_o)
    );

    // Screen RAM port B: one-cycle read latency, data = address.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (ram_cs_o) ram_dat_i <= {18'b0, ram_adr_o};
    end

    always @(negedge clk_i) begin
        if (ram_cs_o) begin
            iss_q.push_back(ram_adr_o);
            iss_t.push_back(cyc);
        end
        if (cell_valid_o && cell_ready_i) begin
            cel_q.push_back(cell_o);
            cel_t.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        iss_q.delete();
        iss_t.delete();
        cel_q.delete();
        cel_t.delete();
    endtask

    task automatic start_row(input logic [13:0] base, input logic [7:0] cols);
        start_i = 1'b1;
        base_i  = base;
        cols_i  = cols;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy_o) break;
            tick();
        end
        chk(tag, 32'(busy_o), 32'h0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_cs"},    32'(ram_cs_o),     32'h0);
        chk({tag, "_adr"},   32'(ram_adr_o),    32'h0);
        chk({tag, "_valid"}, 32'(cell_valid_o), 32'h0);
        chk({tag, "_busy"},  32'(busy_o),       32'h0);
        chk({tag, "_ovr"},   32'(ovr_o),        32'h0);
        chk({tag, "_cell"},  cell_o,            32'h0);
    endtask

    task automatic chk_row(input string tag, input logic [13:0] base, input int n);
        logic [13:0] a;
        chk({tag, "_nissue"}, 32'(iss_q.size()), 32'(n));
        chk({tag, "_ncell"},  32'(cel_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            a = base + 14'(i);
            if (i < iss_q.size()) chk({tag, "_issue_adr"}, 32'(iss_q[i]), 32'(a));
            if (i < cel_q.size()) chk({tag, "_cell"}, cel_q[i], {18'b0, a});
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        base_i       = '0;
        cols_i       = '0;
        cell_ready_i = 1'b1;
        ram_dat_i    = '0;
`ifdef RF_TEXT_FETCH_CURSOR_EN
        cursor_adr_i = '0;
        cursor_en_i  = 1'b0;
`endif
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();
        chk_outputs_zero("reset");

        // Basic row with latency and full-rate checks.
        clear_logs();
        start_row(14'h0100, 8'd8);
        chk("basic_busy_e0", 32'(busy_o), 32'h1);
        chk("basic_cs_e0",   32'(ram_cs_o), 32'h0);
        tick();
        chk("basic_cs_e1",   32'(ram_cs_o), 32'h1);
        chk("basic_adr_e1",  32'(ram_adr_o), 32'h0100);
        tick();
        chk("basic_valid_e2", 32'(cell_valid_o), 32'h0);
        tick();
        chk("basic_valid_e3", 32'(cell_valid_o), 32'h1);
        chk("basic_cell_e3",  cell_o, 32'h0000_0100);
        wait_idle("basic_idle", 50);
        chk_row("basic", 14'h0100, 8);
        if (iss_t.size() == 8) chk("basic_issue_span", 32'(iss_t[7] - iss_t[0]), 32'd7);
        if (cel_t.size() == 8) chk("basic_cell_span",  32'(cel_t[7] - cel_t[0]), 32'd7);

        // Backpressure: only FIFO_DEPTH reads may go out while the consumer stalls.
        clear_logs();
        cell_ready_i = 1'b0;
        start_row(14'h0200, 8'd40);
        repeat (40) tick();
        chk("bp_nissue_stalled", 32'(iss_q.size()), 32'd16);
        chk("bp_cs_stalled",     32'(ram_cs_o), 32'h0);
        chk("bp_valid_stalled",  32'(cell_valid_o), 32'h1);
        chk("bp_head_stalled",   cell_o, 32'h0000_0200);
        cell_ready_i = 1'b1;
        wait_idle("bp_idle", 300);
        chk_row("bp", 14'h0200, 40);

        // Address wrap at the top of screen RAM.
        clear_logs();
        start_row(14'h3FFE, 8'd4);
        wait_idle("wrap_idle", 50);
        chk_row("wrap", 14'h3FFE, 4);

        // Zero-length start is a no-op.
        clear_logs();
        start_row(14'h0050, 8'd0);
        chk("zero_busy_e0", 32'(busy_o), 32'h0);
        repeat (5) tick();
        chk("zero_busy",   32'(busy_o), 32'h0);
        chk("zero_nissue", 32'(iss_q.size()), 32'h0);

        // Overrun: second start two cycles into a 20-cell row.
        clear_logs();
        chk("ovr_before", 32'(ovr_o), 32'h0);
        start_row(14'h0300, 8'd20);
        tick();
        start_row(14'h0500, 8'd5);
        chk("ovr_set", 32'(ovr_o), 32'h1);
        wait_idle("ovr_idle", 100);
        chk_row("ovr", 14'h0300, 20);
        chk("ovr_sticky", 32'(ovr_o), 32'h1);

`ifdef RF_TEXT_FETCH_CURSOR_EN
        clear_logs();
        cursor_adr_i = 14'h0103;
        cursor_en_i  = 1'b1;
        start_row(14'h0100, 8'd8);
        wait_idle("cur_idle", 50);
        chk("cur_ncell", 32'(cel_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < cel_q.size())
                chk("cur_cell", cel_q[i], (i == 3) ? 32'h8000_0103 : 32'(32'h100 + i));
        clear_logs();
        cursor_en_i = 1'b0;
        start_row(14'h0100, 8'd8);
        wait_idle("cur_off_idle", 50);
        chk_row("cur_off", 14'h0100, 8);
`endif

        // Reset in the middle of a 40-cell row.
        clear_logs();
        start_row(14'h0400, 8'd40);
        repeat (5) tick();
        rst_ni = 1'b0;
        tick();
        chk_outputs_zero("midrst");
        tick();
        rst_ni = 1'b1;
        clear_logs();
        repeat (20) tick();
        chk("midrst_nissue", 32'(iss_q.size()), 32'h0);
        chk("midrst_ncell",  32'(cel_q.size()), 32'h0);
        chk("midrst_busy",   32'(busy_o), 32'h0);
        chk("midrst_valid",  32'(cell_valid_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
